calc_operand_entry: RTL and testbench



---
 rtl/calc_pkg.sv | 13 +
 rtl/key_debouncer.sv | 62 ++++++
 rtl/calc_operand_entry.sv | 83 ++++++++
 tb/tb_calc_operand_entry.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and FSM state type for the calculator operand entry path
package calc_pkg;

    localparam int CALC_WIDTH           = 4;
    localparam int CALC_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        S_ENTER_A = 2'd0,
        S_ENTER_B = 2'd1,
        S_SHOW    = 2'd2
    } state_t;

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 2-flop synchronizer, stability debouncer and press pulse for one active-low key
module key_debouncer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int QUIET = DEBOUNCE_CYCLES + 2;
    localparam int QW    = $clog2(QUIET);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [QW-1:0]    QUIET_MAX = QW'(QUIET - 1);

    logic             sync1, sync2;
    logic             level, level_prev;
    logic [CNT_W-1:0] cnt;
    logic [QW-1:0]    quiet;
    logic             armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            level      <= 1'b1;
            level_prev <= 1'b1;
            cnt        <= '0;
            quiet      <= '0;
            armed      <= 1'b0;
        end else begin
            sync1      <= key_n;
            sync2      <= sync1;
            level_prev <= level;
            if (sync2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            // A key held through reset must be seen released (past the sync pipe) before it may fire.
            if (!armed) begin
                if (sync2 && level) begin
                    if (quiet == QUIET_MAX) armed <= 1'b1;
                    else                    quiet <= quiet + 1'b1;
                end else begin
                    quiet <= '0;
                end
            end
        end
    end

    assign press = armed & level_prev & ~level;

endmodule

// File: rtl/calc_operand_entry.sv
// rtl/calc_operand_entry.sv - debounced key entry FSM capturing operands A, B and their registered sum
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH           = CALC_WIDTH,
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_key_enter_n,
    input  logic             i_key_clear_n,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH:0]   o_sum,
    output logic             o_sum_valid,
    output logic [1:0]       o_state
);

    logic   enter_press, clear_press;
    state_t state;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .key_n (i_key_enter_n),
        .press (enter_press)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .key_n (i_key_clear_n),
        .press (clear_press)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_ENTER_A;
            o_a         <= '0;
            o_b         <= '0;
            o_sum       <= '0;
            o_sum_valid <= 1'b0;
        end else if (clear_press) begin
            state       <= S_ENTER_A;
            o_a         <= '0;
            o_b         <= '0;
            o_sum       <= '0;
            o_sum_valid <= 1'b0;
        end else begin
            case (state)
                S_ENTER_A: if (enter_press) begin
                    o_a   <= i_sw;
                    state <= S_ENTER_B;
                end
                S_ENTER_B: if (enter_press) begin
                    o_b         <= i_sw;
                    o_sum       <= {1'b0, o_a} + {1'b0, i_sw};
                    o_sum_valid <= 1'b1;
                    state       <= S_SHOW;
                end
                S_SHOW: if (enter_press) begin
                    o_a         <= '0;
                    o_b         <= '0;
                    o_sum       <= '0;
                    o_sum_valid <= 1'b0;
                    state       <= S_ENTER_A;
                end
                // Unused encoding: fall back to a clean start.
                default: begin
                    o_a         <= '0;
                    o_b         <= '0;
                    o_sum       <= '0;
                    o_sum_valid <= 1'b0;
                    state       <= S_ENTER_A;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_calc_operand_entry.sv
// tb/tb_calc_operand_entry.sv - randomized self-checking bench for calc_operand_entry against a step model
module tb_calc_operand_entry;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       enter_n = 1'b1;
    logic       clear_n = 1'b1;
    logic [3:0] o_a, o_b;
    logic [4:0] o_sum;
    logic       o_sum_valid;
    logic [1:0] o_state;

    int n_total = 0;
    int n_pass  = 0;

    // Reference: which entry step we are on and the values the user has entered.
    int m_step  = 0;
    int m_a     = 0;
    int m_b     = 0;
    int m_sum   = 0;
    int m_valid = 0;

    calc_operand_entry #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sw          (sw),
        .i_key_enter_n (enter_n),
        .i_key_clear_n (clear_n),
        .o_a           (o_a),
        .o_b           (o_b),
        .o_sum         (o_sum),
        .o_sum_valid   (o_sum_valid),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a"},     int'(o_a),         m_a);
        check({tag, ".b"},     int'(o_b),         m_b);
        check({tag, ".sum"},   int'(o_sum),       m_sum);
        check({tag, ".valid"}, int'(o_sum_valid), m_valid);
        check({tag, ".state"}, int'(o_state),     m_step);
    endtask

    task automatic model_clear();
        m_step = 0; m_a = 0; m_b = 0; m_sum = 0; m_valid = 0;
    endtask

    task automatic model_enter(input int v);
        case (m_step)
            0: begin m_a = v; m_step = 1; end
            1: begin m_b = v; m_sum = m_a + v; m_valid = 1; m_step = 2; end
            default: model_clear();
        endcase
    endtask

    // Clean press: checks no update at edge 6 and the update at edge 7 after the raw fall.
    task automatic press(input bit use_clear, input bit use_enter, input int v, input string tag);
        @(negedge clk);
        sw = 4'(v);
        if (use_clear) clear_n = 1'b0;
        if (use_enter) enter_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 check_all({tag, ".pre"});
        @(posedge clk);
        #1;
        if (use_clear) model_clear();
        else           model_enter(v);
        check_all({tag, ".post"});
        repeat (3) @(posedge clk);
        @(negedge clk);
        enter_n = 1'b1;
        clear_n = 1'b1;
        sw = 4'($urandom_range(0, 15));
        repeat (12) @(posedge clk);
        #1 check_all({tag, ".rel"});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);

        press(0, 1, 3, "add3");
        press(0, 1, 9, "add9");
        check("add_sum12", int'(o_sum), 12);
        press(0, 1, 0, "show_exit");

        press(0, 1, 15, "c15a");
        press(0, 1, 15, "c15b");
        check("carry30", int'(o_sum), 30);
        press(0, 1, 0, "c_exit");
        press(0, 1, 8, "c8a");
        press(0, 1, 8, "c8b");
        check("carry16", int'(o_sum), 16);
        press(1, 0, 0, "clr1");

        // Bouncing enter: 20 cycles toggling every 2 cycles, then held low.
        @(negedge clk);
        sw = 4'd6;
        for (int i = 0; i < 5; i++) begin
            enter_n = 1'b0;
            repeat (2) @(negedge clk);
            enter_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        enter_n = 1'b0;
        repeat (12) @(posedge clk);
        #1 model_enter(6);
        check_all("bounce");
        @(negedge clk);
        enter_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 check_all("bounce.rel");

        @(negedge clk);
        sw = 4'd11;
        enter_n = 1'b0;
        repeat (3) @(negedge clk);
        enter_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 check_all("glitch");

        // State is S_ENTER_B (A=6): simultaneous enter and clear.
        press(1, 1, 2, "prio");

        press(0, 1, 5, "pre_rst");
        check("pre_rst_a5", int'(o_a), 5);
        do_reset("rst_mid");
        repeat (12) @(posedge clk);
        #1 check_all("rst_after");

        @(negedge clk);
        sw = 4'd7;
        enter_n = 1'b0;
        repeat (3) @(posedge clk);
        do_reset("held_rst");
        repeat (20) @(posedge clk);
        #1 check_all("held_low");
        @(negedge clk);
        enter_n = 1'b1;
        repeat (15) @(posedge clk);
        #1 check_all("held_rel");
        press(0, 1, 4, "held_p1");
        press(0, 1, 10, "held_p2");
        press(0, 1, 1, "held_p3");
        check("held_p3_state", int'(o_state), 0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) press(1, 0, 0, "rnd_clr");
            else                           press(0, 1, int'($urandom_range(0, 15)), "rnd_ent");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
